// File: rtl/fieldious_mem_pkg.sv
// Shared definitions for the DFFRAM read-side clients: reader FSM states,
// memory read latency and the depth of the reader's skid FIFO.
package fieldious_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } reader_state_t;

    // The DFFRAM read port returns data exactly one cycle after csb1 is low.
    localparam int MEM_RD_LATENCY = 1;

    // Enough slots to cover one word being handed off, one in flight and one
    // being issued, so a consumer holding ready high sees one word per cycle.
    localparam int READER_FIFO_DEPTH = 3;

endpackage

// File: rtl/stream_fifo_d3.sv
// Three-entry synchronous FIFO used to absorb the memory read latency.
// Head word is presented combinationally from storage; count is registered.
module stream_fifo_d3
    import fieldious_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            count
);

    localparam logic [1:0] LAST_SLOT = 2'(READER_FIFO_DEPTH - 1);
    localparam logic [1:0] FULL      = 2'(READER_FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [READER_FIFO_DEPTH];
    logic [1:0]            rd_ptr;
    logic [1:0]            wr_ptr;
    logic                  do_push;
    logic                  do_pop;

    // Pointers wrap at the depth, which is not a power of two.
    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == LAST_SLOT) ? 2'd0 : p + 2'd1;
    endfunction

    // Pops from an empty FIFO are ignored; a push into a full FIFO only lands
    // when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop  = pop && (count != 2'd0);
        do_push = push && ((count != FULL) || do_pop);
        head    = mem[rd_ptr];
    end

    // Storage has no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dffram_stream_reader.sv
// Read-side client for the DFFRAM wrapper: turns a (base address, length)
// command into a burst of reads on the active-low port and streams the
// returned words out with valid/ready and a last flag.
module dffram_stream_reader
    import fieldious_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  start_len,
    output logic                  busy,
    output logic                  done,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam logic [2:0] CREDITS = 3'(READER_FIFO_DEPTH);

    reader_state_t               state;
    logic [ADDR_WIDTH-1:0]       cur_addr;
    logic [ADDR_WIDTH-1:0]       last_addr;
    logic [LEN_WIDTH-1:0]        issue_left;
    logic [LEN_WIDTH-1:0]        len_q;
    logic [LEN_WIDTH-1:0]        deliver_cnt;
    logic [MEM_RD_LATENCY-1:0]   inflight;
    logic                        done_q;
    logic [1:0]                  fifo_count;
    logic [DATA_WIDTH-1:0]       fifo_head;
    logic                        issue;
    logic                        pop;
    logic                        accept;

    // Issue decision uses only registered occupancy, so out_ready never
    // reaches csb1/addr1 combinationally; reset suppresses any activity.
    always_comb begin
        issue       = !rst && (state == RUN) &&
                      (({1'b0, fifo_count} + {2'b00, inflight}) < CREDITS);
        csb1        = !issue;
        addr1       = issue ? cur_addr : last_addr;
        out_valid   = !rst && (fifo_count != 2'd0);
        out_data    = fifo_head;
        pop         = out_valid && out_ready;
        out_last    = out_valid && (deliver_cnt == (len_q - LEN_WIDTH'(1)));
        start_ready = !rst && (state == IDLE);
        accept      = start_valid && start_ready;
        busy        = (state != IDLE);
        done        = done_q;
    end

    // Reader FSM with address, issue and delivery counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cur_addr    <= '0;
            last_addr   <= '0;
            issue_left  <= '0;
            len_q       <= '0;
            deliver_cnt <= '0;
            inflight    <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            inflight <= issue;

            if (issue) begin
                cur_addr   <= cur_addr + ADDR_WIDTH'(1);
                last_addr  <= cur_addr;
                issue_left <= issue_left - LEN_WIDTH'(1);
            end

            if (pop) begin
                deliver_cnt <= deliver_cnt + LEN_WIDTH'(1);
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (start_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            cur_addr    <= start_addr;
                            len_q       <= start_len;
                            issue_left  <= start_len;
                            deliver_cnt <= '0;
                            state       <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue && (issue_left == LEN_WIDTH'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    stream_fifo_d3 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight[0]),
        .push_data(dout1),
        .pop      (pop),
        .head     (fifo_head),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_dffram_stream_reader.sv
// Directed bench for dffram_stream_reader with a behavioural DFFRAM read port.
module tb_dffram_stream_reader;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [AW-1:0] start_addr;
    logic [LW-1:0] start_len;
    logic          busy;
    logic          done;
    logic          csb1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] dout1 = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    int checks = 0;
    int errors = 0;

    int issued;
    int popped;
    int max_out;
    int last_cnt;
    int last_pos;
    int done_cnt;
    int busy_seen;
    logic [DW-1:0] got_q [$];

    // Hand-derived per-cycle expectations for addr=0x10, len=4, ready held.
    logic          t1_csb   [1:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [AW-1:0] t1_addr  [1:7] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h13, 8'h13, 8'h13};
    logic          t1_valid [1:7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [DW-1:0] t1_data  [1:7] = '{32'h0, 32'h0, 32'hD000_0010, 32'hD000_0011,
                                      32'hD000_0012, 32'hD000_0013, 32'h0};
    logic          t1_last  [1:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic          t1_done  [1:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic          t1_busy  [1:7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [AW-1:0] t2_addr  [4]   = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    dffram_stream_reader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .start_addr (start_addr),
        .start_len  (start_len),
        .busy       (busy),
        .done       (done),
        .csb1       (csb1),
        .addr1      (addr1),
        .dout1      (dout1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    // Memory contents are a recognisable tag plus the address.
    function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
        return {24'hD00000, a};
    endfunction

    // Behavioural DFFRAM read port: one-cycle latency while csb1 is low.
    always @(posedge clk) begin
        if (!csb1) begin
            dout1 <= memWord(addr1);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic sv, input logic [AW-1:0] a,
                                 input logic [LW-1:0] l, input logic rdy);
        start_valid = sv;
        start_addr  = a;
        start_len   = l;
        out_ready   = rdy;
    endtask

    task automatic clearMon();
        issued    = 0;
        popped    = 0;
        max_out   = 0;
        last_cnt  = 0;
        last_pos  = 0;
        done_cnt  = 0;
        busy_seen = 0;
        got_q.delete();
    endtask

    // Called once per cycle after that cycle's inputs are applied.
    task automatic monitorCycle();
        if (!csb1) issued++;
        if (issued - popped > max_out) max_out = issued - popped;
        if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            if (out_last) begin
                last_cnt++;
                last_pos = got_q.size();
            end
            popped++;
        end
        if (done) done_cnt++;
        if (busy) busy_seen++;
    endtask

    task automatic startBurst(input logic [AW-1:0] a, input logic [LW-1:0] l);
        clearMon();
        nextCycle();
        applyStimulus(1'b1, a, l, 1'b1);
        monitorCycle();
        checkOutput("start_ready_at_accept", start_ready, 1);
    endtask

    // Runs until done or the cycle budget expires, then confirms done was a pulse.
    task automatic finishBurst(input int budget, input int ready_pct);
        for (int c = 0; c < budget && done_cnt == 0; c++) begin
            nextCycle();
            start_valid = 1'b0;
            out_ready = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(99)) < ready_pct);
            monitorCycle();
        end
        checkOutput("done_seen", done_cnt, 1);
        nextCycle();
        out_ready = 1'b1;
        monitorCycle();
        checkOutput("done_single_pulse", done_cnt, 1);
    endtask

    task automatic checkWords(input string tag, input logic [AW-1:0] base, input int len);
        int bad;
        logic [AW-1:0] a;
        bad = 0;
        checkOutput({tag, "_count"}, got_q.size(), len);
        for (int i = 0; i < got_q.size() && i < len; i++) begin
            a = base + AW'(i);
            if (got_q[i] !== memWord(a)) bad++;
        end
        checkOutput({tag, "_order"}, bad, 0);
        checkOutput({tag, "_last_count"}, last_cnt, 1);
        checkOutput({tag, "_last_pos"}, last_pos, len);
    endtask

    initial begin
        clearMon();
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 9'd0, 1'b0);

        // Reset values while reset is held.
        nextCycle();
        nextCycle();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_csb1", csb1, 1);
        checkOutput("rst_addr1", addr1, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_start_ready", start_ready, 0);
        rst = 1'b0;
        nextCycle();
        checkOutput("post_rst_start_ready", start_ready, 1);

        // Basic burst with ready held high, checked cycle by cycle.
        $display("[TB] burst addr=0x10 len=4");
        startBurst(8'h10, 9'd4);
        for (int k = 1; k <= 7; k++) begin
            nextCycle();
            applyStimulus(1'b0, 8'h00, 9'd0, 1'b1);
            monitorCycle();
            checkOutput($sformatf("t1_csb1_c%0d", k), csb1, t1_csb[k]);
            checkOutput($sformatf("t1_addr1_c%0d", k), addr1, t1_addr[k]);
            checkOutput($sformatf("t1_valid_c%0d", k), out_valid, t1_valid[k]);
            if (t1_valid[k]) checkOutput($sformatf("t1_data_c%0d", k), out_data, t1_data[k]);
            checkOutput($sformatf("t1_last_c%0d", k), out_last, t1_last[k]);
            checkOutput($sformatf("t1_done_c%0d", k), done, t1_done[k]);
            checkOutput($sformatf("t1_busy_c%0d", k), busy, t1_busy[k]);
        end
        nextCycle();
        monitorCycle();
        checkOutput("t1_done_cleared", done, 0);
        checkOutput("t1_reads", issued, 4);
        checkWords("t1", 8'h10, 4);

        // Address wrap from 0xFE.
        $display("[TB] burst addr=0xFE len=4");
        startBurst(8'hFE, 9'd4);
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            applyStimulus(1'b0, 8'h00, 9'd0, 1'b1);
            monitorCycle();
            checkOutput($sformatf("t2_csb1_%0d", k), csb1, 0);
            checkOutput($sformatf("t2_addr1_%0d", k), addr1, t2_addr[k]);
        end
        finishBurst(20, 100);
        checkWords("t2", 8'hFE, 4);
        if (got_q.size() == 4) checkOutput("t2_word2", got_q[2], 32'hD000_0000);

        // Backpressure: ready low from T+2 to T+10.
        $display("[TB] burst addr=0x20 len=8 with backpressure");
        startBurst(8'h20, 9'd8);
        for (int k = 1; k <= 11; k++) begin
            nextCycle();
            applyStimulus(1'b0, 8'h00, 9'd0, (k >= 2 && k <= 10) ? 1'b0 : 1'b1);
            monitorCycle();
        end
        checkOutput("t3_reads_before_pop", issued, 3);
        checkOutput("t3_csb1_at_pop", csb1, 1);
        checkOutput("t3_first_pop", popped, 1);
        nextCycle();
        out_ready = 1'b1;
        monitorCycle();
        checkOutput("t3_resume_csb1", csb1, 0);
        checkOutput("t3_resume_addr1", addr1, 8'h23);
        finishBurst(50, 100);
        checkWords("t3", 8'h20, 8);
        checkOutput("t3_outstanding_le3", max_out <= 3, 1);

        // Zero-length command.
        $display("[TB] burst len=0");
        startBurst(8'h55, 9'd0);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 9'd0, 1'b1);
        monitorCycle();
        checkOutput("t4_done", done, 1);
        checkOutput("t4_busy", busy, 0);
        checkOutput("t4_csb1", csb1, 1);
        checkOutput("t4_out_valid", out_valid, 0);
        checkOutput("t4_start_ready", start_ready, 1);
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            monitorCycle();
        end
        checkOutput("t4_no_reads", issued, 0);
        checkOutput("t4_busy_seen", busy_seen, 0);
        checkOutput("t4_no_words", popped, 0);
        checkOutput("t4_done_count", done_cnt, 1);

        // Reset in the middle of a burst, then a fresh short burst.
        $display("[TB] reset mid-burst");
        startBurst(8'h80, 9'd6);
        for (int k = 1; k <= 5; k++) begin
            nextCycle();
            applyStimulus(1'b0, 8'h00, 9'd0, 1'b1);
            monitorCycle();
        end
        checkOutput("t5_third_valid", out_valid, 1);
        checkOutput("t5_third_data", out_data, 32'hD000_0082);
        rst = 1'b1;
        nextCycle();
        checkOutput("t5_rst_csb1", csb1, 1);
        checkOutput("t5_rst_out_valid", out_valid, 0);
        checkOutput("t5_rst_busy", busy, 0);
        rst = 1'b0;
        nextCycle();
        checkOutput("t5_after_csb1", csb1, 1);
        checkOutput("t5_after_out_valid", out_valid, 0);
        checkOutput("t5_after_busy", busy, 0);
        startBurst(8'h40, 9'd2);
        finishBurst(20, 100);
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            monitorCycle();
        end
        checkWords("t5", 8'h40, 2);

        // Full-memory burst with random backpressure, wrapping from 0x37.
        $display("[TB] burst addr=0x37 len=256 random ready");
        startBurst(8'h37, 9'd256);
        finishBurst(4000, 50);
        checkWords("t6", 8'h37, 256);
        checkOutput("t6_outstanding_le3", max_out <= 3, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
